// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern and overlap mode.
// Define MATCH_CNT_EN to build the saturating match counter.
module seq_pattern_detector #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             data_in,
    input  logic             cfg_overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_ARM = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;

    logic             accept;
    logic [PAT_W-1:0] nxt;
    logic [FW-1:0]    fill_inc;
    logic             hit;

    // A beat coinciding with a pattern load is dropped.
    always_comb begin
        accept   = in_valid & ~cfg_load;
        nxt      = {hist[PAT_W-2:0], data_in};
        fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
        hit      = accept && (fill >= FILL_ARM) && (nxt == pat_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= PATTERN;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (accept) begin
                hist <= nxt;
                // Non-overlap restarts the fill so PAT_W fresh bits are needed.
                fill <= (hit && !cfg_overlap) ? '0 : fill_inc;
            end
        end
    end

`ifdef MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= '0;
        end else if (hit && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
